// File: rtl/collatz_range.sv
// Batch Collatz engine: evaluates RAM_WORDS consecutive starting values into an
// internal RAM, then serves registered reads addressed by start's low bits.
module collatz_range #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [31:0] start,
    output logic        done,
    output logic [15:0] count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [31:0]              base;
    logic [31:0]              v;
    logic [15:0]              c;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic [15:0]              ram [RAM_WORDS];
    logic                     iter_end;
    logic                     last_word;
    logic                     ram_we;

    // One Collatz step; 3v+1 wraps at 32 bits.
    function automatic logic [31:0] collatz_step(input logic [31:0] x);
        if (x[0])
            return x + {x[30:0], 1'b0} + 32'd1;
        else
            return {1'b0, x[31:1]};
    endfunction

    assign iter_end  = (v <= 32'd1) || (c == 16'hFFFF);
    assign last_word = (idx == RAM_ADDR_BITS'(RAM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // go restarts from any state; reset has priority through the state register.
    always_comb begin
        state_nxt = state;
        if (go) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOAD:    state_nxt = ITER;
                ITER:    if (iter_end) state_nxt = WRITE;
                WRITE:   state_nxt = last_word ? DONE : LOAD;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        done   = (state == DONE);
        ram_we = (state == WRITE);
    end

    // Working registers carry no reset; they are reloaded before use.
    always_ff @(posedge clk) begin
        if (go) begin
            base <= start;
            idx  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    v <= base;
                    c <= (base == 32'd0) ? 16'd0 : 16'd1;
                end
                ITER: begin
                    if (!iter_end) begin
                        v <= collatz_step(v);
                        c <= c + 16'd1;
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        idx  <= idx + RAM_ADDR_BITS'(1);
                        base <= base + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[idx] <= c;
    end

    // Read port runs in every state so the panel sees data one cycle after addressing.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= ram[start[RAM_ADDR_BITS-1:0]];
    end

endmodule

// File: doc/collatz_range.md
# collatz_range

Batch Collatz engine that sits directly downstream of the lab 1 front panel. On a one-cycle `go` pulse it computes the Collatz iteration count for `RAM_WORDS` consecutive starting values beginning at `start`, storing each result in an internal RAM. It then raises `done`. After `done`, the panel reuses `start` as a RAM read address and displays `count`.

## Interface

Parameters:
- `RAM_WORDS`, default 256: number of consecutive values evaluated per run.
- `RAM_ADDR_BITS`, default 8: RAM address width; must satisfy 2**RAM_ADDR_BITS >= RAM_WORDS.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1: system clock, 50 MHz.
- `reset`  input  1: synchronous, active-high; overrides every other input.
- `go`  input  1: one-cycle start pulse; sampled in every state.
- `start`  input  32: on `go`, the first value of the range; while `done`=1, `start[RAM_ADDR_BITS-1:0]` is the read address.
- `done`  output  1: high once all `RAM_WORDS` results are written; held until the next `go` or `reset`.
- `count`  output  16: registered RAM read data for address `start[RAM_ADDR_BITS-1:0]`.

## Operation

- Internal state:
  - `base` (32 b): value under evaluation.
  - `v` (32 b): Collatz working value.
  - `c` (16 b): running count.
  - `idx` (RAM_ADDR_BITS b): current write address.
- FSM states: IDLE, LOAD, ITER, WRITE, DONE.
- IDLE:
  - `done`=0; waits for `go`.
  - `go` latches `base`=`start` and `idx`=0, then moves to LOAD.
- LOAD:
  - `v`=`base`.
  - `c`=0 if `base`==0, else `c`=1.
  - Moves to ITER.
- ITER, one step per cycle:
  - If `v`==0, `v`==1, or `c`==16'hFFFF, move to WRITE.
  - Otherwise, if `v` is even then `v`=`v`>>1; if odd then `v`=3*`v`+1, truncated to 32 bits. `c` increments.
- WRITE:
  - RAM[`idx`]=`c`.
  - If `idx`==RAM_WORDS-1, move to DONE.
  - Otherwise `idx`++, `base`++ (32-bit, wraps 0xFFFFFFFF to 0), and move to LOAD.
- DONE: `done`=1; stays until `go` or `reset`.
- Count definition: number of values in the sequence, including the start value and the final 1.
  - n=1 gives 1; n=2 gives 2; n=3 gives 8; n=4 gives 3; n=27 gives 112.
  - n=0 gives 0.
  - Counts saturate at 0xFFFF, which also terminates that value.
- RAM:
  - Simple dual-port, `RAM_WORDS` x 16.
  - Write port is driven only in WRITE.
  - The read port reads `start[RAM_ADDR_BITS-1:0]` every cycle, in every state.
  - Contents are not cleared by reset or `go`.
- `go` in any state other than IDLE (including ITER, WRITE, DONE):
  - Aborts the current activity and restarts from the new `start`.
  - `done` drops the next cycle.
- Boundary rules:
  - `reset` and `go` in the same cycle: reset wins.
  - `reset` mid-run: goes to IDLE, `done`=0; partially written RAM entries remain.

## Timing

- Reset values: `done`=0, `count`=0, state IDLE. `base`, `v`, `c` and `idx` are don't-care until the next LOAD.
- `go` sampled high at edge k puts the FSM in LOAD after edge k, so `done`=0 from edge k on.
- Cycles per value:
  - `c`+2 (LOAD + `c` ITER cycles + WRITE) when `c`>=1, where ITER cycles = `c` (steps taken + 1 terminating check).
  - 3 cycles when `c`=0.
- Total run cycles = sum of per-value cycles over `RAM_WORDS` values. `done` is high on the edge after the final WRITE.
- Read latency: `count` reflects the address presented at edge k after edge k+1 (one registered cycle). This holds in all states. Values are meaningful only while `done`=1.
- No throughput requirement beyond one Collatz step per clock.

## Test plan

- Reset, then `go` with `start`=1 (`RAM_WORDS`=256):
  - `done` rises.
  - Reading addresses 0, 1, 2, 3, 26 gives `count` = 1, 2, 8, 3, 112.
- Small-run cycle accuracy, `RAM_WORDS`=4, `RAM_ADDR_BITS`=2, `start`=1:
  - Per-value cycles are 3, 4, 10, 5.
  - `done` is exactly 22 cycles after the LOAD entry cycle, and is 0 before that.
- `start`=0 run:
  - RAM[0]=0 and RAM[1]=1.
  - `start`=0xFFFFFFFF: RAM[0] is the saturating/wrapped result, RAM[1] (n=0) = 0, RAM[2] (n=1) = 1.
- Read latency with `done`=1:
  - Change `start` low bits 2→26 at edge k; `count` changes 8→112 after edge k+1.
- Second `go` mid-run (during ITER) with `start`=5:
  - `done` stays 0.
  - On completion RAM[0]=6 (n=5), RAM[22]=112 (n=27).
- `reset` asserted mid-run, and `reset` together with `go`:
  - `done`=0 and `count`=0 after the edge.
  - FSM is in IDLE; no LOAD follows.
